alu_share_arb: RTL and testbench

- Shares one combinational 4-bit ALU datapath (adder/logic unit with sum, cout and overflow outputs) between NREQ requesters.
- Each requester issues func/a/b with a valid/ready handshake. The arbiter grants one requester, drives the ALU, captures the result and flags, and returns a response tagged with the requester id.
- Sits between the switch/test front-ends and the ALU; it is the only block driving ALU operand inputs.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/alu_share_arb.sv | 157 +++++++++++++++
 tb/tb_alu_share_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM state encoding
// and the op-code mapping used when driving the shared ALU.
package alu_arb_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Compare ops reuse the ALU subtractor; everything else passes through.
  function automatic logic [2:0] alu_drive_func(input logic [2:0] op);
    return (op == OP_SLT || op == OP_EQ) ? OP_SUB : op;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic: round robin from ptr by default, or fixed
// lowest-index priority when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    grant     = '0;
    grant_idx = '0;
    // Scanning downward lets the lowest requesting index write last and win.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    // Distance k from ptr is the priority rank; the smallest rank writes last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (((i + NREQ - int'(ptr)) % NREQ) == k)) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters through an
// IDLE/EXEC/CAPT/RESP sequence. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_func,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_cout,
  output logic                  resp_ovf,
  output logic                  resp_zero,
  output logic [2:0]            alu_func,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_sum,
  input  logic                  alu_cout,
  input  logic                  alu_ovf
);

  state_t           state, state_nxt;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   arb_ptr;
  logic             accept;
  logic [2:0]       lat_func;
  logic [IDW-1:0]   lat_id;
  logic [WIDTH-1:0] capt_data;
  logic             capt_cout;
  logic             capt_ovf;
  logic [2:0]       sel_func;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept   = (state == ST_IDLE) && (|req_valid);
  assign sel_func = req_func[grant_idx*3 +: 3];

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (state == ST_RESP && resp_ready) begin
      rr_ptr <= (resp_id == IDW'(NREQ - 1)) ? '0 : resp_id + 1'b1;
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by reset so no accept pulse escapes while the block is held in reset.
        if (rst) req_ready = grant;
        if (|req_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_CAPT;
      ST_CAPT: state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The ALU operand registers double as the request latch, so the shared ALU
  // only ever sees captured values and holds them between operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_func <= OP_ADD;
      lat_id   <= '0;
      alu_func <= OP_ADD;
      alu_a    <= '0;
      alu_b    <= '0;
    end else if (accept) begin
      lat_func <= sel_func;
      lat_id   <= grant_idx;
      alu_func <= alu_drive_func(sel_func);
      alu_a    <= req_a[grant_idx*WIDTH +: WIDTH];
      alu_b    <= req_b[grant_idx*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    capt_data = '0;
    capt_cout = 1'b0;
    capt_ovf  = 1'b0;
    case (lat_func)
      OP_ADD, OP_SUB: begin
        capt_data = alu_sum;
        capt_cout = alu_cout;
        capt_ovf  = alu_ovf;
      end
      OP_NOT: capt_data = ~alu_a;
      OP_AND: capt_data = alu_a & alu_b;
      OP_OR:  capt_data = alu_a | alu_b;
      OP_XOR: capt_data = alu_a ^ alu_b;
      OP_SLT: capt_data = {{(WIDTH-1){1'b0}}, alu_sum[WIDTH-1] ^ alu_ovf};
      OP_EQ:  capt_data = {{(WIDTH-1){1'b0}}, alu_sum == '0};
      default: capt_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_id   <= '0;
      resp_data <= '0;
      resp_cout <= 1'b0;
      resp_ovf  <= 1'b0;
    end else if (state == ST_CAPT) begin
      resp_id   <= lat_id;
      resp_data <= capt_data;
      resp_cout <= capt_cout;
      resp_ovf  <= capt_ovf;
    end
  end

  // Zero flag is only meaningful alongside a response, which also keeps it low out of reset.
  assign resp_zero = resp_valid && (resp_data == '0);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a behavioural 4-bit ALU.
module tb_alu_share_arb;
  localparam int NREQ  = 2;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_func;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_data;
  logic                  resp_cout;
  logic                  resp_ovf;
  logic                  resp_zero;
  logic [2:0]            alu_func;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_sum;
  logic                  alu_cout;
  logic                  alu_ovf;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_cout  (resp_cout),
    .resp_ovf   (resp_ovf),
    .resp_zero  (resp_zero),
    .alu_func   (alu_func),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sum    (alu_sum),
    .alu_cout   (alu_cout),
    .alu_ovf    (alu_ovf)
  );

  always #5 clk = ~clk;

  // Shared ALU: func 001 subtracts (a + ~b + 1), everything else adds.
  logic             alu_cin;
  logic [WIDTH-1:0] alu_bv;
  assign alu_cin = (alu_func == 3'b001);
  assign alu_bv  = alu_cin ? ~alu_b : alu_b;
  assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_bv} + {4'b0, alu_cin};
  assign alu_ovf = (alu_a[3] == alu_bv[3]) && (alu_sum[3] != alu_a[3]);

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from requester id; called #1 after a clock edge in IDLE.
  task automatic run_op(input int id, input logic [2:0] func, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] e_data, input logic e_cout,
                        input logic e_ovf, input logic e_zero);
    int lat;
    logic [2:0] e_af;
    e_af = (func[2:1] == 2'b11) ? 3'b001 : func;
    req_func[id*3 +: 3]         = func;
    req_a[id*WIDTH +: WIDTH]    = a;
    req_b[id*WIDTH +: WIDTH]    = b;
    req_valid                   = 2'(1) << id;
    #1;
    check("req_ready", req_ready, 2'(1) << id);
    tick();
    req_valid = '0;
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_func", alu_func, e_af);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 3);
    check("resp_id", resp_id, id);
    check("resp_data", resp_data, e_data);
    check("resp_cout", resp_cout, e_cout);
    check("resp_ovf", resp_ovf, e_ovf);
    check("resp_zero", resp_zero, e_zero);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 1'b0);
  endtask

  initial begin
    int seen;
    int ng;
    int bad;
    int gidx [4];
    int gcyc [4];
    int exp_g [4];

    rst        = 1'b0;
    req_valid  = 2'b01;
    req_func   = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 4'h0);
    check("rst_resp_zero", resp_zero, 1'b0);
    check("rst_alu_func", alu_func, 3'b000);
    check("rst_alu_a", alu_a, 4'h0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Arithmetic, compare and logic ops across both requesters.
    run_op(0, 3'b000, 4'h7, 4'h9, 4'h0, 1'b1, 1'b0, 1'b1);
    run_op(1, 3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
    run_op(0, 3'b001, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0);
    run_op(1, 3'b110, 4'h9, 4'h2, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op(0, 3'b110, 4'h2, 4'h9, 4'h0, 1'b0, 1'b0, 1'b1);
    run_op(1, 3'b111, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op(1, 3'b111, 4'h5, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1);
    run_op(0, 3'b101, 4'hA, 4'h6, 4'hC, 1'b0, 1'b0, 1'b0);
    run_op(1, 3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
    run_op(1, 3'b100, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0);
    run_op(0, 3'b010, 4'h3, 4'hF, 4'hC, 1'b0, 1'b0, 1'b0);

    // Reset while an op sits in EXEC.
    req_func[2:0] = 3'b000;
    req_a[3:0]    = 4'h1;
    req_b[3:0]    = 4'h1;
    req_valid     = 2'b01;
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 2'b00);
    check("midrst_alu_a", alu_a, 4'h0);
    check("midrst_alu_b", alu_b, 4'h0);
    check("midrst_alu_func", alu_func, 3'b000);
    check("midrst_resp_data", resp_data, 4'h0);
    #2;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("midrst_no_resp", seen, 0);

    // Both requesters continuously valid with an always-ready consumer.
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    req_func   = '0;
    req_a      = '0;
    req_b      = '0;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    ng  = 0;
    bad = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req_ready == 2'b11) bad++;
      if (|req_ready) begin
        gidx[ng] = req_ready[1] ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grants", ng, 4);
    check("rr_onehot", bad, 0);
    for (int i = 0; i < 4; i++) check("rr_order", gidx[i], exp_g[i]);
    for (int i = 1; i < 4; i++) check("rr_interval", gcyc[i] - gcyc[i-1], 4);
    for (int i = 0; i < 4; i++) tick();
    resp_ready = 1'b0;

    // Back-pressure: response held while req1 waits.
    req_func[2:0] = 3'b000;
    req_a[3:0]    = 4'h1;
    req_b[3:0]    = 4'h2;
    req_valid     = 2'b01;
    tick();
    req_func[5:3] = 3'b000;
    req_a[7:4]    = 4'h4;
    req_b[7:4]    = 4'h4;
    req_valid     = 2'b10;
    seen = 0;
    while (!resp_valid && seen < 10) begin
      tick();
      seen++;
    end
    check("bp_resp_valid", resp_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!resp_valid || resp_data != 4'h3 || resp_id != 2'd0 || req_ready != 2'b00) bad++;
      tick();
    end
    check("bp_stable", bad, 0);
    resp_ready = 1'b1;
    #1;
    check("bp_hs_no_ready", req_ready, 2'b00);
    tick();
    resp_ready = 1'b0;
    run_op(1, 3'b000, 4'h4, 4'h4, 4'h8, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
